// File: rtl/sfr_shadow_checker_pkg.sv
// Shared types and helpers for the double-buffered SFR shadow checker.
package sfr_chk_pkg;

    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2
    } chk_state_e;

    // Word index of a byte address relative to the bank base; range checks are left to the caller.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset >> 2;
    endfunction

endpackage

// File: rtl/sfr_shadow_checker_if.sv
// APB snoop bundle observed by the SFR shadow checker.
interface sfr_shadow_checker_if #(
    parameter int ADDR_W = 8
);
    logic                                psel;
    logic                                penable;
    logic                                pwrite;
    logic                                pready;
    logic [ADDR_W-1:0]                   paddr;
    logic [sfr_chk_pkg::APB_DATA_W-1:0]  pwdata;

    modport master (output psel, penable, pwrite, pready, paddr, pwdata);
    modport slave  (input  psel, penable, pwrite, pready, paddr, pwdata);
endinterface

// File: rtl/sfr_shadow_checker_reg_bank.sv
// One checked SFR word: pending/active shadow pair and live-value compare.
module sfr_chk_reg_bank
    import sfr_chk_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic [DATA_W-1:0] dut_val,
    input  logic              excluded,
    output logic [DATA_W-1:0] active,
    output logic              mism
);
    logic [DATA_W-1:0] pending;

    // commit reads the old pending, so a write on the commit edge belongs to the next frame
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            pending <= '0;
            active  <= '0;
        end else begin
            if (commit) active  <= pending;
            if (wr_en)  pending <= wr_data;
        end
    end

    assign mism = !excluded && (dut_val != active);

endmodule

// File: rtl/sfr_shadow_checker.sv
// Shadow checker for double-buffered SFR banks; define SFR_CHK_ASSERT_EN for per-register
// simulation assertions, otherwise only the flag outputs are produced.
//
// state | meaning
// IDLE  | no compare pending
// WAIT  | delay counter running after a VSYNC rise
// CHECK | one cycle, live SFRs compared against active shadow
module sfr_shadow_checker
    import sfr_chk_pkg::*;
#(
    parameter int          NUM_REGS    = 12,
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 8,
    parameter int unsigned BASE_ADDR   = 'h00,
    parameter int          CHECK_DELAY = 10,
    parameter int          CNT_W       = 16
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    sfr_shadow_checker_if.slave          apb,
    input  logic                         i_VSYNC,
    input  logic                         i_check_enable,
    input  logic [NUM_REGS-1:0]          i_cmp_mask,
    input  logic [NUM_REGS*DATA_W-1:0]   i_dut_sfr,
    input  logic                         i_err_clr,
    output logic                         o_busy,
    output logic                         o_err_pulse,
    output logic [NUM_REGS-1:0]          o_err_mask,
    output logic [CNT_W-1:0]             o_err_count,
    output logic                         o_first_valid,
    output logic [$clog2(NUM_REGS)-1:0]  o_first_idx
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int DLY_W = $clog2(CHECK_DELAY + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_CHECK = CHECK;

    logic [1:0]                 state;
    logic [DLY_W-1:0]           dly_cnt;
    logic                       vsync_prev;
    logic                       vsync_rise;
    logic [31:0]                wr_idx;
    logic                       wr_ok;
    logic [NUM_REGS-1:0]        mism;
    logic [NUM_REGS*DATA_W-1:0] active_flat;
    logic                       cmp_fire;
    logic                       any_mism;
    logic [IDX_W-1:0]           low_idx;
    logic                       unused_wdata;

    assign vsync_rise   = i_VSYNC && !vsync_prev;
    assign wr_idx       = addr_to_idx(32'(apb.paddr), BASE_ADDR);
    assign wr_ok        = apb.psel && apb.penable && apb.pwrite && apb.pready
                          && (32'(apb.paddr) >= BASE_ADDR) && (apb.paddr[1:0] == 2'b00)
                          && (wr_idx < 32'(NUM_REGS));
    assign unused_wdata = ^apb.pwdata[APB_DATA_W-1:DATA_W];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        sfr_chk_reg_bank #(.DATA_W(DATA_W)) u_bank (
            .i_CLK    (i_CLK),
            .i_RST    (i_RST),
            .wr_en    (wr_ok && (wr_idx == 32'(k))),
            .wr_data  (apb.pwdata[DATA_W-1:0]),
            .commit   (vsync_rise),
            .dut_val  (i_dut_sfr[k*DATA_W +: DATA_W]),
            .excluded (i_cmp_mask[k]),
            .active   (active_flat[k*DATA_W +: DATA_W]),
            .mism     (mism[k])
        );
    end

    always_comb begin
        low_idx = '0;
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            if (mism[k]) low_idx = IDX_W'(k);
        end
    end

    assign cmp_fire = (state == ST_CHECK) && i_check_enable;
    assign any_mism = cmp_fire && (|mism);
    assign o_busy   = (state == ST_WAIT);

    // a rise in WAIT or CHECK reloads the delay, so only the latest frame is compared
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state      <= ST_IDLE;
            dly_cnt    <= '0;
            vsync_prev <= 1'b0;
        end else begin
            vsync_prev <= i_VSYNC;
            if (!i_check_enable) begin
                state <= ST_IDLE;
            end else if (vsync_rise) begin
                state   <= ST_WAIT;
                dly_cnt <= DLY_W'(CHECK_DELAY - 1);
            end else begin
                case (state)
                    ST_WAIT: begin
                        if (dly_cnt == '0) state   <= ST_CHECK;
                        else               dly_cnt <= dly_cnt - DLY_W'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // a compare result landing with i_err_clr is kept: clear first, then record
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            o_err_pulse   <= 1'b0;
            o_err_mask    <= '0;
            o_err_count   <= '0;
            o_first_valid <= 1'b0;
            o_first_idx   <= '0;
        end else begin
            o_err_pulse <= any_mism;
            if (i_err_clr) begin
                o_err_mask    <= any_mism ? mism : '0;
                o_err_count   <= any_mism ? CNT_W'(1) : '0;
                o_first_valid <= any_mism;
                o_first_idx   <= any_mism ? low_idx : '0;
            end else if (any_mism) begin
                o_err_mask <= o_err_mask | mism;
                if (o_err_count != '1) o_err_count <= o_err_count + CNT_W'(1);
                if (!o_first_valid) begin
                    o_first_valid <= 1'b1;
                    o_first_idx   <= low_idx;
                end
            end
        end
    end

`ifdef SFR_CHK_ASSERT_EN
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_sva
        property p_match;
            @(posedge i_CLK) disable iff (!i_RST || !i_check_enable || i_cmp_mask[k])
            $rose(i_VSYNC) |-> ##CHECK_DELAY
                (i_dut_sfr[k*DATA_W +: DATA_W] == active_flat[k*DATA_W +: DATA_W]);
        endproperty
        a_match: assert property (p_match)
            else $error("sfr_shadow_checker: reg %0d expected %h actual %h", k,
                        active_flat[k*DATA_W +: DATA_W], i_dut_sfr[k*DATA_W +: DATA_W]);
    end
`else
    logic unused_active;
    assign unused_active = ^active_flat;
`endif

endmodule

// File: tb/tb_sfr_shadow_checker.sv
// Directed + randomized bench for sfr_shadow_checker against a cycle-level behavioural model.
module tb_sfr_shadow_checker;
    import sfr_chk_pkg::*;

    localparam int N  = 12;
    localparam int DW = 16;
    localparam int D  = 10;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sfr_shadow_checker_if #(.ADDR_W(8)) apb ();

    logic            vsync, en, clr;
    logic [N-1:0]    cmask;
    logic [DW-1:0]   dut_v [N];
    logic [N*DW-1:0] dut_flat;
    logic            busy, pulse, fvalid;
    logic [N-1:0]    emask;
    logic [CW-1:0]   ecount;
    logic [3:0]      fidx;

    always_comb begin
        dut_flat = '0;
        for (int k = 0; k < N; k++) dut_flat[k*DW +: DW] = dut_v[k];
    end

    sfr_shadow_checker #(
        .NUM_REGS(N), .DATA_W(DW), .ADDR_W(8), .BASE_ADDR('h00), .CHECK_DELAY(D), .CNT_W(CW)
    ) dut (
        .i_CLK(clk), .i_RST(rst_n), .apb(apb), .i_VSYNC(vsync), .i_check_enable(en),
        .i_cmp_mask(cmask), .i_dut_sfr(dut_flat), .i_err_clr(clr), .o_busy(busy),
        .o_err_pulse(pulse), .o_err_mask(emask), .o_err_count(ecount),
        .o_first_valid(fvalid), .o_first_idx(fidx)
    );

    // model: shadows as arrays, compare scheduled by absolute edge number
    logic [DW-1:0] m_pend [N];
    logic [DW-1:0] m_act  [N];
    logic          m_vprev, m_sched, m_pulse, m_busy, m_fv;
    logic [N-1:0]  m_mask;
    int            m_cmp_at, m_count, m_idx, cyc;
    int            vectors = 0;
    int            miscompares = 0;
    int            npulse;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin m_pend[k] = '0; m_act[k] = '0; end
        m_vprev = 0; m_sched = 0; m_pulse = 0; m_busy = 0; m_fv = 0;
        m_mask = '0; m_count = 0; m_idx = 0; m_cmp_at = 0;
    endtask

    task automatic model_edge();
        logic rise, fire, wr;
        logic [N-1:0] mm;
        rise = vsync && !m_vprev;
        fire = m_sched && (cyc == m_cmp_at) && en;
        mm = '0;
        if (fire)
            for (int k = 0; k < N; k++) if (!cmask[k] && dut_v[k] !== m_act[k]) mm[k] = 1'b1;
        m_pulse = (mm != '0);
        if (clr) begin m_mask = '0; m_count = 0; m_fv = 0; m_idx = 0; end
        if (mm != '0) begin
            m_mask |= mm;
            if (m_count < CMAX) m_count++;
            if (!m_fv) begin
                m_fv = 1;
                for (int k = N - 1; k >= 0; k--) if (mm[k]) m_idx = k;
            end
        end
        wr = apb.psel && apb.penable && apb.pwrite && apb.pready
             && (apb.paddr % 4 == 0) && (apb.paddr / 4 < N);
        if (rise) m_act = m_pend;
        if (wr) m_pend[apb.paddr / 4] = apb.pwdata[DW-1:0];
        if (!en || fire) m_sched = 0;
        if (rise && en) begin m_sched = 1; m_cmp_at = cyc + D + 1; end
        m_busy = m_sched && (cyc < m_cmp_at - 1);
        m_vprev = vsync;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy",        32'(busy),   32'(m_busy));
        chk("err_pulse",   32'(pulse),  32'(m_pulse));
        chk("err_mask",    32'(emask),  32'(m_mask));
        chk("err_count",   32'(ecount), 32'(m_count));
        chk("first_valid", 32'(fvalid), 32'(m_fv));
        chk("first_idx",   32'(fidx),   32'(m_idx));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic apb_idle();
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb.psel = 1; apb.pwrite = 1; apb.paddr = a; apb.pwdata = d; apb.penable = 0; apb.pready = 1;
        tick();
        apb.penable = 1;
        tick();
        apb_idle();
    endtask

    task automatic frame(input int n);
        vsync = 1; tick();
        vsync = 0;
        repeat (n) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; vsync = 0; en = 1; clr = 0; cmask = '0; cyc = 0;
        apb_idle(); apb.pready = 1; apb.paddr = '0; apb.pwdata = '0;
        for (int k = 0; k < N; k++) dut_v[k] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        #2 rst_n = 1;

        // matching write
        apb_write(8'h08, 32'h1E0);
        dut_v[2] = 16'h1E0;
        frame(11);
        chk("t1_count", 32'(ecount), 32'h0);
        chk("t1_mask",  32'(emask),  32'h0);

        // reg5 mismatch, pulse exactly 11 edges after the rise
        apb_write(8'h14, 32'hA);
        vsync = 1; tick(); vsync = 0;
        repeat (10) tick();
        chk("t2_early_pulse", 32'(pulse), 32'h0);
        tick();
        chk("t2_pulse", 32'(pulse),  32'h1);
        chk("t2_mask",  32'(emask),  32'h020);
        chk("t2_count", 32'(ecount), 32'h1);
        chk("t2_fidx",  32'(fidx),   32'h5);
        dut_v[5] = 16'hA;

        // out-of-range and misaligned writes are ignored
        apb_write(8'h30, 32'h55);
        apb_write(8'h05, 32'h77);
        frame(12);
        chk("t3_count", 32'(ecount), 32'h1);

        // write landing on the rise edge goes to the next frame
        apb.psel = 1; apb.pwrite = 1; apb.paddr = 8'h00; apb.pwdata = 32'h1234; apb.penable = 0;
        tick();
        apb.penable = 1; vsync = 1;
        tick();
        apb_idle(); vsync = 0;
        repeat (11) tick();
        chk("t4_old_frame", 32'(ecount), 32'h1);
        dut_v[0] = 16'h1234;
        frame(12);
        chk("t4_new_frame", 32'(ecount), 32'h1);

        // restart 4 edges after the first rise, reg3 masked
        dut_v[3] = 16'hBEEF; cmask[3] = 1;
        frame(3);
        frame(13);
        chk("t5_masked", 32'(ecount), 32'h1);
        cmask[3] = 0;
        npulse = 0;
        vsync = 1; tick(); vsync = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (pulse === 1'b1) npulse++; end
        vsync = 1; tick(); vsync = 0;
        for (int i = 0; i < 14; i++) begin tick(); if (pulse === 1'b1) npulse++; end
        chk("t5_one_pulse", 32'(npulse), 32'h1);

        // enable drop mid-WAIT discards the compare
        vsync = 1; tick(); vsync = 0;
        repeat (4) tick();
        en = 0; tick(); en = 1;
        repeat (12) tick();
        chk("t6_count", 32'(ecount), 32'h2);

        // clear coinciding with a compare result: result wins
        vsync = 1; tick(); vsync = 0;
        repeat (10) tick();
        clr = 1; tick(); clr = 0;
        chk("t7_mask",  32'(emask),  32'h008);
        chk("t7_count", 32'(ecount), 32'h1);
        chk("t7_fidx",  32'(fidx),   32'h3);
        clr = 1; tick(); clr = 0;
        chk("t8_mask",  32'(emask),  32'h0);
        chk("t8_valid", 32'(fvalid), 32'h0);

        // counter saturation
        for (int f = 0; f < CMAX + 2; f++) frame(11);
        chk("t9_sat", 32'(ecount), 32'(CMAX));

        // async reset in WAIT
        vsync = 1; tick(); vsync = 0;
        repeat (4) tick();
        chk("t10_busy_before", 32'(busy), 32'h1);
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #2 rst_n = 1;
        repeat (14) tick();
        chk("t10_count", 32'(ecount), 32'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            apb.psel    = 1'($urandom_range(1));
            apb.penable = 1'($urandom_range(1));
            apb.pwrite  = 1'($urandom_range(1));
            apb.pready  = ($urandom_range(3) != 0);
            apb.paddr   = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(N - 1) * 4);
            apb.pwdata  = $urandom;
            if ($urandom_range(7) == 0) vsync = ~vsync;
            en  = ($urandom_range(31) != 0);
            clr = ($urandom_range(39) == 0);
            if ($urandom_range(49) == 0) cmask = N'($urandom);
            for (int k = 0; k < N; k++)
                dut_v[k] = ($urandom_range(63) == 0) ? (m_act[k] ^ (16'(1) << $urandom_range(DW - 1)))
                                                     : m_act[k];
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
